writeback_64: RTL and testbench

WRITEBACK_64 -- requirements
Module: writeback_64

---
 rtl/writeback_64.sv | 135 +++++++++++++
 tb/tb_writeback_64.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/writeback_64.sv
// Writeback stage: W pipeline register, 15 x 64-bit register file with
// combinational read ports, program status, sticky halt flag and a
// retired-instruction counter.
module writeback_64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        W_stall,
   input  logic [3:0]  M_stat,
   input  logic [3:0]  M_icode,
   input  logic [63:0] M_valE,
   input  logic [63:0] m_valM,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic [3:0]  srcA,
   input  logic [3:0]  srcB,
   output logic [63:0] rvalA,
   output logic [63:0] rvalB,
   output logic [3:0]  W_stat,
   output logic [3:0]  W_icode,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM,
   output logic [3:0]  Stat,
   output logic        halted,
   output logic [63:0] retired
);

   localparam logic [3:0] STAT_AOK = 4'd1;
   localparam logic [3:0] STAT_HLT = 4'd2;
   localparam logic [3:0] STAT_ADR = 4'd3;
   localparam logic [3:0] STAT_INS = 4'd4;
   localparam logic [3:0] ICODE_NOP = 4'd1;
   localparam logic [3:0] REG_NONE = 4'hF;

   logic [3:0]  w_stat_reg;
   logic [3:0]  w_icode_reg;
   logic [63:0] w_vale_reg;
   logic [63:0] w_valm_reg;
   logic [3:0]  w_dste_reg;
   logic [3:0]  w_dstm_reg;
   logic        halted_reg;
   logic [63:0] retired_reg;

   // Register file entries; slot 15 of the read view is the constant-zero "none" ID.
   logic [63:0] rf_reg [0:14];
   logic [63:0] rd_view [0:15];

   logic commit;
   logic halt_edge;
   logic retire_inc;

   // Write enable and halt/retire qualifiers derived from current W contents.
   always_comb begin
      commit     = !W_stall && !halted_reg && (w_stat_reg == STAT_AOK);
      halt_edge  = !W_stall && ((w_stat_reg == STAT_HLT) ||
                                (w_stat_reg == STAT_ADR) ||
                                (w_stat_reg == STAT_INS));
      retire_inc = (commit && (w_icode_reg != ICODE_NOP)) ||
                   (halt_edge && !halted_reg && (w_stat_reg == STAT_HLT));
   end

   // W pipeline register: loads from M unless stalled, bubble on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_stat_reg  <= STAT_AOK;
         w_icode_reg <= ICODE_NOP;
         w_vale_reg  <= 64'd0;
         w_valm_reg  <= 64'd0;
         w_dste_reg  <= REG_NONE;
         w_dstm_reg  <= REG_NONE;
      end else if (!W_stall) begin
         w_stat_reg  <= M_stat;
         w_icode_reg <= M_icode;
         w_vale_reg  <= M_valE;
         w_valm_reg  <= m_valM;
         w_dste_reg  <= M_dstE;
         w_dstm_reg  <= M_dstM;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 15; gi++) begin : g_rf
         // One register entry: valM port has priority when both ports target it.
         always_ff @(posedge clk) begin
            if (rst) begin
               rf_reg[gi] <= 64'd0;
            end else if (commit && (w_dstm_reg == 4'(gi))) begin
               rf_reg[gi] <= w_valm_reg;
            end else if (commit && (w_dste_reg == 4'(gi))) begin
               rf_reg[gi] <= w_vale_reg;
            end
         end
         assign rd_view[gi] = rf_reg[gi];
      end
   endgenerate

   assign rd_view[15] = 64'd0;

   // Combinational read ports, no write bypass.
   always_comb begin
      rvalA = rd_view[srcA];
      rvalB = rd_view[srcB];
   end

   // Sticky halt flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         halted_reg <= 1'b0;
      end else if (halt_edge) begin
         halted_reg <= 1'b1;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^64.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_reg <= 64'd0;
      end else if (retire_inc) begin
         retired_reg <= retired_reg + 64'd1;
      end
   end

   assign W_stat  = w_stat_reg;
   assign W_icode = w_icode_reg;
   assign W_valE  = w_vale_reg;
   assign W_valM  = w_valm_reg;
   assign W_dstE  = w_dste_reg;
   assign W_dstM  = w_dstm_reg;
   assign Stat    = w_stat_reg;
   assign halted  = halted_reg;
   assign retired = retired_reg;

endmodule

// File: tb/tb_writeback_64.sv
module tb_writeback_64;

   logic        clk = 1'b0;
   logic        rst;
   logic        W_stall;
   logic [3:0]  M_stat, M_icode, M_dstE, M_dstM, srcA, srcB;
   logic [63:0] M_valE, m_valM;
   logic [63:0] rvalA, rvalB, W_valE, W_valM, retired;
   logic [3:0]  W_stat, W_icode, W_dstE, W_dstM, Stat;
   logic        halted;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   writeback_64 dut (
      .clk(clk), .rst(rst), .W_stall(W_stall),
      .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE), .m_valM(m_valM),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .srcA(srcA), .srcB(srcB),
      .rvalA(rvalA), .rvalB(rvalB), .W_stat(W_stat), .W_icode(W_icode),
      .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
      .Stat(Stat), .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input logic [63:0] obs);
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic drive_m(input logic [3:0] st, input logic [3:0] ic,
                          input logic [3:0] de, input logic [63:0] ve,
                          input logic [3:0] dm, input logic [63:0] vm);
      M_stat = st; M_icode = ic; M_dstE = de; M_valE = ve; M_dstM = dm; m_valM = vm;
   endtask

   task automatic bubble();
      drive_m(4'd1, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0);
   endtask

   initial begin
      rst = 1'b1; W_stall = 1'b0; srcA = 4'hF; srcB = 4'hF;
      drive_m(4'd3, 4'd6, 4'd7, 64'hDEAD, 4'd8, 64'hBEEF);
      tick(); tick();
      rst = 1'b0; bubble(); srcA = 4'd3;

      // Reset state
      push("reset_stat", 64'd1);       pop_check({60'd0, Stat});
      push("reset_halted", 64'd0);     pop_check({63'd0, halted});
      push("reset_retired", 64'd0);    pop_check(retired);
      push("reset_w_dstE", 64'hF);     pop_check({60'd0, W_dstE});
      push("reset_w_icode", 64'd1);    pop_check({60'd0, W_icode});
      push("reset_r3", 64'd0);         pop_check(rvalA);

      // Two-edge latency into register 3
      drive_m(4'd1, 4'd3, 4'd3, 64'h55, 4'hF, 64'd0);
      push("lat_first_edge_r3", 64'd0);
      tick(); pop_check(rvalA);
      bubble();
      push("lat_second_edge_r3", 64'h55);
      push("lat_retired", 64'd1);
      tick(); pop_check(rvalA); pop_check(retired);

      // Same destination on both ports: valM wins
      drive_m(4'd1, 4'hB, 4'd4, 64'h100, 4'd4, 64'h200);
      srcB = 4'd4;
      tick(); bubble();
      push("popq_r4", 64'h200);
      push("popq_retired", 64'd2);
      tick(); pop_check(rvalB); pop_check(retired);

      // Stall holds and suppresses the write; written once on release
      drive_m(4'd1, 4'd3, 4'd2, 64'h7, 4'hF, 64'd0);
      srcA = 4'd2;
      tick();
      bubble(); W_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push("stall_r2", 64'd0);
         push("stall_w_valE", 64'h7);
         push("stall_retired", 64'd2);
         tick(); pop_check(rvalA); pop_check(W_valE); pop_check(retired);
      end
      W_stall = 1'b0;
      push("release_r2", 64'h7);
      push("release_retired", 64'd3);
      tick(); pop_check(rvalA); pop_check(retired);
      push("after_release_retired", 64'd3);
      tick(); pop_check(retired);

      // ID F reads as zero
      srcA = 4'hF; srcB = 4'hF;
      push("srcA_none", 64'd0);        pop_check(rvalA);
      push("srcB_none", 64'd0);        pop_check(rvalB);

      // ADR halts the machine, later AOK writes are dropped
      srcA = 4'd1;
      drive_m(4'd3, 4'd5, 4'd1, 64'h9, 4'hF, 64'd0);
      tick();
      push("adr_stat", 64'd3);         pop_check({60'd0, Stat});
      push("adr_not_yet_halted", 64'd0); pop_check({63'd0, halted});
      drive_m(4'd1, 4'd3, 4'd1, 64'h11, 4'hF, 64'd0);
      tick();
      push("adr_halted", 64'd1);       pop_check({63'd0, halted});
      push("adr_r1", 64'd0);           pop_check(rvalA);
      bubble();
      tick();
      push("halted_r1_ignored", 64'd0); pop_check(rvalA);
      push("halted_retired", 64'd3);   pop_check(retired);
      push("halted_sticky", 64'd1);    pop_check({63'd0, halted});

      // HLT counts once on its halting edge
      rst = 1'b1; tick(); rst = 1'b0;
      drive_m(4'd2, 4'd0, 4'hF, 64'd0, 4'hF, 64'd0);
      tick(); bubble();
      push("hlt_halted", 64'd1);
      push("hlt_retired", 64'd1);
      tick(); pop_check({63'd0, halted}); pop_check(retired);
      push("hlt_retired_frozen", 64'd1);
      tick(); pop_check(retired);

      // Reset discards an in-flight write and clears the file
      rst = 1'b1; tick(); rst = 1'b0;
      drive_m(4'd1, 4'd3, 4'd5, 64'hAA, 4'hF, 64'd0);
      srcA = 4'd5; srcB = 4'd6;
      tick();
      drive_m(4'd1, 4'd3, 4'd6, 64'hBB, 4'hF, 64'd0);
      tick();
      push("preload_r5", 64'hAA);      pop_check(rvalA);
      bubble(); rst = 1'b1;
      push("rst_r5", 64'd0);
      push("rst_r6", 64'd0);
      push("rst_retired", 64'd0);
      push("rst_w_dstE", 64'hF);
      tick(); pop_check(rvalA); pop_check(rvalB); pop_check(retired); pop_check({60'd0, W_dstE});
      rst = 1'b0;
      tick();
      push("post_rst_r6", 64'd0);      pop_check(rvalB);

      if (exp_q.size() != 0) begin
         bad++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
